alu_seq: RTL

//  Registered, handshaked successor to the combinational ALU. Width is parametrised.

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered valid/ready ALU: one operation at a time, result held until out_ready.
// Op codes: AND=0 XOR=1 OR=2 NOR=3 ADD=4 SUB=5 SLT=6 SRL=7 SLL=8 SRA=9 MUL=F, others reserved.
// Define ALU_MUL_EN to build the iterative signed MUL; otherwise ALU_OP_MUL is reserved.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             equal,
    output logic             overflow,
    output logic             zero
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] ALU_OP_AND = 4'h0;
    localparam logic [3:0] ALU_OP_XOR = 4'h1;
    localparam logic [3:0] ALU_OP_OR  = 4'h2;
    localparam logic [3:0] ALU_OP_NOR = 4'h3;
    localparam logic [3:0] ALU_OP_ADD = 4'h4;
    localparam logic [3:0] ALU_OP_SUB = 4'h5;
    localparam logic [3:0] ALU_OP_SLT = 4'h6;
    localparam logic [3:0] ALU_OP_SRL = 4'h7;
    localparam logic [3:0] ALU_OP_SLL = 4'h8;
    localparam logic [3:0] ALU_OP_SRA = 4'h9;

`ifdef ALU_MUL_EN
    localparam logic [3:0] ALU_OP_MUL = 4'hF;
    localparam int         CNT_W      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_e;
`endif

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] z_q;
    logic             eq_q;
    logic             ovf_q;
    logic             zero_q;

    logic             accept;
    logic [WIDTH-1:0] z_d;
    logic             ovf_d;
    logic             eq_d;
    logic             zero_d;
    logic             valid_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;

    assign accept = in_valid && in_ready_q;
    assign sum    = X + Y;
    assign diff   = X - Y;
    assign shamt  = Y[SH_W-1:0];

    // Single-cycle ops are evaluated on the live operands and registered at the accept edge.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        z_d      = '0;
        ovf_d    = 1'b0;
        valid_op = 1'b1;
        case (op_code)
            ALU_OP_AND: z_d = X & Y;
            ALU_OP_XOR: z_d = X ^ Y;
            ALU_OP_OR:  z_d = X | Y;
            ALU_OP_NOR: z_d = ~(X | Y);
            ALU_OP_ADD: begin
                z_d   = sum;
                ovf_d = (X[WIDTH-1] == Y[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                z_d   = diff;
                ovf_d = (X[WIDTH-1] != Y[WIDTH-1]) && (diff[WIDTH-1] != X[WIDTH-1]);
            end
            ALU_OP_SLT: z_d = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            ALU_OP_SRL: z_d = X >> shamt;
            ALU_OP_SLL: z_d = X << shamt;
            ALU_OP_SRA: z_d = $signed(X) >>> shamt;
            default:    valid_op = 1'b0;
        endcase
        eq_d   = valid_op && (X == Y);
        zero_d = valid_op && (z_d == '0);
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               mul_eq_q;

    logic [WIDTH-1:0]   mag_x;
    logic [WIDTH-1:0]   mag_y;
    logic [2*WIDTH-1:0] prod_d;
    logic               mul_last;
    logic               mul_ovf;

    // Magnitude of the most negative value is still correct read as unsigned.
    assign mag_x    = X[WIDTH-1] ? -X : X;
    assign mag_y    = Y[WIDTH-1] ? -Y : Y;
    assign mul_last = (cnt_q == CNT_W'(WIDTH));
    assign prod_d   = neg_q ? -acc_q : acc_q;
    assign mul_ovf  = (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}});

    // NOTE: the multiplier datapath has no reset; it is fully loaded on accept before any use.
    always_ff @(posedge clk) begin
        if (accept && (op_code == ALU_OP_MUL)) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mag_x};
            mplier_q <= mag_y;
            cnt_q    <= '0;
            neg_q    <= X[WIDTH-1] ^ Y[WIDTH-1];
            mul_eq_q <= (X == Y);
        end else if ((state_q == S_EXEC) && !mul_last) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            eq_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
`ifdef ALU_MUL_EN
                        if (op_code == ALU_OP_MUL) begin
                            state_q <= S_EXEC;
                        end else
`endif
                        begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            z_q         <= z_d;
                            eq_q        <= eq_d;
                            ovf_q       <= ovf_d;
                            zero_q      <= zero_d;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                S_EXEC: begin
                    if (mul_last) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        z_q         <= prod_d[WIDTH-1:0];
                        eq_q        <= mul_eq_q;
                        ovf_q       <= mul_ovf;
                        zero_q      <= (prod_d[WIDTH-1:0] == '0);
                    end
                end
`endif
                S_DONE: begin
                    // Result and flags stay put until the consumer takes them.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign equal     = eq_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
